// File: rtl/rsa_frame_loader_if.sv
// rtl/rsa_frame_loader_if.sv - byte stream, RSA core and result handshake bundle for rsa_frame_loader
//
// Purpose: groups every non-clock/reset signal of rsa_frame_loader.
// Ports (master = the loader, slave = host/core side):
//   rx_data/rx_valid/rx_ready        inbound frame byte stream
//   input_text/key/mod/go            operands and start pulse to the RSA core
//   done/output_text                 RSA core completion level and result
//   result/result_valid/result_ready captured result handshake
//   err/busy                         status
interface rsa_frame_loader_if #(
  parameter int WordSize = 32
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic [WordSize-1:0] input_text;
  logic [WordSize-1:0] key;
  logic [WordSize-1:0] mod;
  logic                go;
  logic                done;
  logic [WordSize-1:0] output_text;
  logic [WordSize-1:0] result;
  logic                result_valid;
  logic                result_ready;
  logic                err;
  logic                busy;

  modport master (
    input  rx_data, rx_valid, done, output_text, result_ready,
    output rx_ready, input_text, key, mod, go, result, result_valid, err, busy
  );

  modport slave (
    output rx_data, rx_valid, done, output_text, result_ready,
    input  rx_ready, input_text, key, mod, go, result, result_valid, err, busy
  );
endinterface

// File: rtl/rsa_frame_loader.sv
// rtl/rsa_frame_loader.sv - parses command frames into RSA operands, runs the core, captures the result
//
// Purpose: accepts frames of one command byte plus NB operand bytes (MSB first).
//   0x01 loads key, 0x02 loads mod, 0x03 loads input_text and runs the RSA core,
//   waiting for a rising edge of done (bounded by TIMEOUT cycles) and holding the
//   result until the consumer accepts it.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    rsa_frame_loader_if.master (stream, core, result and status signals)
module rsa_frame_loader #(
  parameter int WordSize = 32,
  parameter int TIMEOUT  = 4096
) (
  input logic               clk,
  input logic               reset,
  rsa_frame_loader_if.master bus
);

  localparam int NB  = WordSize / 8;
  localparam int BCW = $clog2(NB + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_START,
    ST_WAIT_DONE,
    ST_RESULT
  } state_t;

  state_t              r_state;
  logic [7:0]          r_cmd;
  logic [BCW-1:0]      r_byte_cnt;
  logic [TCW-1:0]      r_wait_cnt;
  logic [WordSize-1:0] r_asm;
  logic [WordSize-1:0] r_key;
  logic [WordSize-1:0] r_mod;
  logic [WordSize-1:0] r_input_text;
  logic [WordSize-1:0] r_result;
  logic                r_result_valid;
  logic                r_done_q;
  logic                r_go;
  logic                r_err;
  logic                r_busy;
  logic                r_rx_ready;

  logic                w_xfer;
  logic                w_done_rise;
  logic [WordSize-1:0] w_asm_next;

  assign w_xfer      = bus.rx_valid & r_rx_ready;
  assign w_done_rise = bus.done & ~r_done_q;
  // The word including the byte arriving on this edge, so the NB-th byte lands directly in the target.
  assign w_asm_next  = (r_asm << 8) | WordSize'(bus.rx_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cmd          <= '0;
      r_byte_cnt     <= '0;
      r_wait_cnt     <= '0;
      r_asm          <= '0;
      r_key          <= '0;
      r_mod          <= '0;
      r_input_text   <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_done_q       <= 1'b0;
      r_go           <= 1'b0;
      r_err          <= 1'b0;
      r_busy         <= 1'b0;
      r_rx_ready     <= 1'b0;
    end else begin
      r_done_q <= bus.done;
      r_go     <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_rx_ready <= 1'b1;
          if (w_xfer) begin
            if (bus.rx_data == 8'h01 || bus.rx_data == 8'h02 || bus.rx_data == 8'h03) begin
              r_cmd      <= bus.rx_data;
              r_byte_cnt <= '0;
              r_state    <= ST_COLLECT;
              r_busy     <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        ST_COLLECT: begin
          if (w_xfer) begin
            r_asm      <= w_asm_next;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == BCW'(NB - 1)) begin
              case (r_cmd)
                8'h01: begin
                  r_key   <= w_asm_next;
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                end
                8'h02: begin
                  r_mod   <= w_asm_next;
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                end
                8'h03: begin
                  r_input_text <= w_asm_next;
                  r_state      <= ST_START;
                  r_go         <= 1'b1;
                  r_rx_ready   <= 1'b0;
                end
                default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                end
              endcase
            end
          end
        end

        ST_START: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT_DONE;
        end

        ST_WAIT_DONE: begin
          // Completion is tested first so it wins over a coincident timeout.
          if (w_done_rise) begin
            r_result       <= bus.output_text;
            r_result_valid <= 1'b1;
            r_state        <= ST_RESULT;
          end else if (r_wait_cnt == TCW'(TIMEOUT - 1)) begin
            r_err      <= 1'b1;
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_rx_ready <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        ST_RESULT: begin
          if (bus.result_ready) begin
            r_result_valid <= 1'b0;
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
            r_rx_ready     <= 1'b1;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_rx_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rx_ready     = r_rx_ready;
  assign bus.input_text   = r_input_text;
  assign bus.key          = r_key;
  assign bus.mod          = r_mod;
  assign bus.go           = r_go;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.err          = r_err;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_rsa_frame_loader.sv
// tb/tb_rsa_frame_loader.sv - directed self-checking bench for rsa_frame_loader
module tb_rsa_frame_loader;

  logic clk;
  logic reset;
  int   total;
  int   passed;
  int   go_cycles;

  rsa_frame_loader_if #(.WordSize(32)) bus ();

  rsa_frame_loader #(.WordSize(32), .TIMEOUT(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.go === 1'b1) go_cycles++;

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) begin
      total++;
      $display("FAIL send_byte_ready actual=%b required=1", bus.rx_ready);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] w);
    send_byte(cmd);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    total++; if (bus.rx_ready !== 1'b0) $display("FAIL reset_rx_ready actual=%b required=0", bus.rx_ready); else passed++;
    total++; if ({bus.go, bus.busy, bus.err, bus.result_valid} !== 4'b0) $display("FAIL reset_flags actual=%b required=0000", {bus.go, bus.busy, bus.err, bus.result_valid}); else passed++;
    total++; if ({bus.key, bus.mod, bus.input_text, bus.result} !== 128'h0) $display("FAIL reset_words actual=%h required=0", {bus.key, bus.mod, bus.input_text, bus.result}); else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.rx_ready !== 1'b1) $display("FAIL release_rx_ready actual=%b required=1", bus.rx_ready); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL release_busy actual=%b required=0", bus.busy); else passed++;
  endtask

  task automatic test_load_key;
    int g0;
    g0 = go_cycles;
    send_frame(8'h01, 32'h00010001);
    total++; if (bus.key !== 32'h00010001) $display("FAIL load_key actual=%h required=00010001", bus.key); else passed++;
    total++; if (bus.rx_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL load_key_idle actual=%b%b required=10", bus.rx_ready, bus.busy); else passed++;
    total++; if (go_cycles !== g0) $display("FAIL load_key_go actual=%0d required=%0d", go_cycles, g0); else passed++;
  endtask

  task automatic test_bad_cmd;
    send_byte(8'h7F);
    total++; if (bus.err !== 1'b1) $display("FAIL bad_cmd_err actual=%b required=1", bus.err); else passed++;
    total++; if (bus.key !== 32'h00010001 || bus.mod !== 32'h0 || bus.input_text !== 32'h0) $display("FAIL bad_cmd_regs actual=%h/%h/%h required=00010001/0/0", bus.key, bus.mod, bus.input_text); else passed++;
    total++; if (bus.rx_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL bad_cmd_idle actual=%b%b required=10", bus.rx_ready, bus.busy); else passed++;
    @(posedge clk); #1;
    total++; if (bus.err !== 1'b0) $display("FAIL bad_cmd_err_pulse actual=%b required=0", bus.err); else passed++;
    send_frame(8'h02, 32'h0000000D);
    total++; if (bus.mod !== 32'h0000000D) $display("FAIL load_mod actual=%h required=0000000D", bus.mod); else passed++;
  endtask

  task automatic test_process;
    int g0;
    g0 = go_cycles;
    send_frame(8'h03, 32'hDEADBEEF);
    total++; if (bus.input_text !== 32'hDEADBEEF) $display("FAIL process_text actual=%h required=DEADBEEF", bus.input_text); else passed++;
    total++; if (bus.go !== 1'b1 || bus.rx_ready !== 1'b0) $display("FAIL process_go actual=%b%b required=10", bus.go, bus.rx_ready); else passed++;
    @(posedge clk); #1;
    total++; if (bus.go !== 1'b0) $display("FAIL process_go_pulse actual=%b required=0", bus.go); else passed++;
    repeat (9) begin @(posedge clk); #1; end
    bus.output_text = 32'h12345678;
    bus.done        = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.result_valid !== 1'b1 || bus.result !== 32'h12345678) $display("FAIL process_result actual=%b/%h required=1/12345678", bus.result_valid, bus.result); else passed++;
    bus.output_text = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (bus.result_valid !== 1'b1 || bus.result !== 32'h12345678) $display("FAIL process_hold%0d actual=%b/%h required=1/12345678", i, bus.result_valid, bus.result); else passed++;
    end
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    bus.done         = 1'b0;
    total++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rx_ready !== 1'b1) $display("FAIL process_accept actual=%b%b%b required=001", bus.result_valid, bus.busy, bus.rx_ready); else passed++;
    total++; if (go_cycles - g0 !== 1) $display("FAIL process_go_count actual=%0d required=1", go_cycles - g0); else passed++;
  endtask

  task automatic test_stale_done;
    int n;
    bus.output_text = 32'hAAAAAAAA;
    bus.done        = 1'b1;
    send_frame(8'h03, 32'h00000001);
    repeat (5) begin @(posedge clk); #1; end
    total++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b1) $display("FAIL stale_ignored actual=%b%b required=01", bus.result_valid, bus.busy); else passed++;
    bus.done        = 1'b0;
    bus.output_text = 32'h0000BEEF;
    @(posedge clk); #1;
    bus.done = 1'b1;
    n = 0;
    while (bus.result_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    total++; if (bus.result_valid !== 1'b1 || bus.result !== 32'h0000BEEF) $display("FAIL stale_result actual=%b/%h required=1/0000BEEF", bus.result_valid, bus.result); else passed++;
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    bus.done         = 1'b0;
  endtask

  task automatic test_timeout;
    int n;
    send_frame(8'h03, 32'h00000002);
    n = 0;
    while (bus.err !== 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    // Edges counted from the 5th transfer: one START edge plus 4096 WAIT_DONE cycles.
    total++; if (n !== 4097) $display("FAIL timeout_latency actual=%0d required=4097", n); else passed++;
    total++; if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.rx_ready !== 1'b1) $display("FAIL timeout_state actual=%b%b%b required=001", bus.busy, bus.result_valid, bus.rx_ready); else passed++;
    @(posedge clk); #1;
    total++; if (bus.err !== 1'b0) $display("FAIL timeout_err_pulse actual=%b required=0", bus.err); else passed++;
  endtask

  task automatic test_reset_midframe;
    send_byte(8'h01);
    send_byte(8'hAA);
    #3;
    reset = 1'b0;
    #1;
    total++; if ({bus.key, bus.mod, bus.input_text, bus.result} !== 128'h0) $display("FAIL midreset_words actual=%h required=0", {bus.key, bus.mod, bus.input_text, bus.result}); else passed++;
    total++; if ({bus.rx_ready, bus.busy, bus.go, bus.err, bus.result_valid} !== 5'b0) $display("FAIL midreset_flags actual=%b required=00000", {bus.rx_ready, bus.busy, bus.go, bus.err, bus.result_valid}); else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h03, 32'h00000005);
    total++; if (bus.input_text !== 32'h00000005 || bus.key !== 32'h0) $display("FAIL midreset_reparse actual=%h/%h required=00000005/0", bus.input_text, bus.key); else passed++;
    total++; if (bus.go !== 1'b1) $display("FAIL midreset_go actual=%b required=1", bus.go); else passed++;
  endtask

  initial begin
    total            = 0;
    passed           = 0;
    go_cycles        = 0;
    bus.rx_data      = 8'h00;
    bus.rx_valid     = 1'b0;
    bus.done         = 1'b0;
    bus.output_text  = 32'h0;
    bus.result_ready = 1'b0;
    test_reset();
    test_load_key();
    test_bad_cmd();
    test_process();
    test_stale_done();
    test_timeout();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
